// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word RAM plus KBSR/KBDR, DSR/DDR with output FIFO, and MCR.
// Optional 16-bit cycle timer at 0xFE08 when LC3_MEM_TIMER_EN is defined.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic              writeEnable,
  input  logic [15:0]       dataToMemory,
  output logic [15:0]       dataFromMemory,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              kbd_ready,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready,
  output logic              halted
);

  localparam int unsigned PW = $clog2(DSP_DEPTH);
  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;
  localparam logic [15:0] TMR  = 16'hFE08;
  localparam logic [15:0] MCR  = 16'hFFFE;

  logic [15:0] mem [2**ADDR_W];

  logic          kb_full_q;
  logic [7:0]    kb_char_q;
  logic [15:0]   prev_addr_q;
  logic          hist_q;
  logic          we_prev_q;
  logic [7:0]    fifo_q [DSP_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          ovf_q;
  logic          run_q;
`ifdef LC3_MEM_TIMER_EN
  logic [15:0]   timer_q;
`endif

  logic              in_ram;
  logic [ADDR_W-1:0] ram_idx;
  logic              fifo_full;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              kbdr_first;

  assign in_ram     = (({16'b0, address}) >> ADDR_W) == 32'd0;
  assign ram_idx    = address[ADDR_W-1:0];
  assign fifo_full  = (count_q == (PW+1)'(DSP_DEPTH));
  assign pop        = (count_q != '0) && dsp_ready;
  assign push_req   = writeEnable && !we_prev_q && (address == DDR);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign kbdr_first = (address == KBDR) && (!hist_q || (prev_addr_q != KBDR));

  assign kbd_ready = ~kb_full_q;
  assign dsp_valid = (count_q != '0);
  assign dsp_data  = dsp_valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign halted    = ~run_q;

  always_comb begin
    dataFromMemory = '0;
    if (in_ram) begin
      dataFromMemory = mem[ram_idx];
    end else begin
      case (address)
        KBSR:    dataFromMemory = {kb_full_q, 15'b0};
        KBDR:    dataFromMemory = {8'b0, kb_char_q};
        DSR:     dataFromMemory = {~fifo_full, 14'b0, ovf_q};
        MCR:     dataFromMemory = {run_q, 15'b0};
`ifdef LC3_MEM_TIMER_EN
        TMR:     dataFromMemory = timer_q;
`endif
        default: dataFromMemory = '0;
      endcase
    end
  end

  // Preload is applied last so it overrides a bus store to the same word.
  always_ff @(posedge clk) begin
    if (writeEnable && in_ram) mem[ram_idx] <= dataToMemory;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_q[wr_ptr_q] <= dataToMemory[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kb_full_q   <= 1'b0;
      kb_char_q   <= '0;
      prev_addr_q <= '0;
      hist_q      <= 1'b0;
      we_prev_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      run_q       <= 1'b1;
    end else begin
      prev_addr_q <= address;
      hist_q      <= 1'b1;
      we_prev_q   <= writeEnable;

      if (kb_full_q) begin
        if (kbdr_first) kb_full_q <= 1'b0;
      end else if (kbd_valid) begin
        kb_char_q <= kbd_data;
        kb_full_q <= 1'b1;
      end

      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop);

      if (push_req && !push_ok) ovf_q <= 1'b1;
      if (writeEnable && (address == DSR)) ovf_q <= 1'b0;

      if (writeEnable && (address == MCR)) run_q <= dataToMemory[15];
    end
  end

`ifdef LC3_MEM_TIMER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (writeEnable && (address == TMR)) begin
      timer_q <= dataToMemory;
    end else begin
      timer_q <= timer_q + 16'd1;
    end
  end
`endif

endmodule
